// File: rtl/ethernet_rx_fcs_checker.sv
// ethernet_rx_fcs_checker: strips and checks the FCS of received Ethernet frames.
// Ports:
//   clk_i, rst_n_i                 clock, synchronous active-low reset
//   rx_valid_i/data_i/last_i/error_i  incoming frame bytes (post-SFD), FCS included
//   data_o, valid_o, last_o        payload stream with the 4 FCS bytes removed
//   frame_done_o                   one-cycle pulse; status outputs below are valid
//   frame_good_o, crc_error_o, length_error_o, phy_error_o, frame_length_o  frame status
module ethernet_rx_fcs_checker #(
    parameter logic [31:0] CRC_RESIDUE = 32'hDEBB20E3,
    parameter int          MIN_FRAME   = 64,
    parameter int          MAX_FRAME   = 1518
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_last_i,
    input  logic        rx_error_i,
    output logic [7:0]  data_o,
    output logic        valid_o,
    output logic        last_o,
    output logic        frame_done_o,
    output logic        frame_good_o,
    output logic        crc_error_o,
    output logic        length_error_o,
    output logic        phy_error_o,
    output logic [15:0] frame_length_o
);
    typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;
    state_t state, state_next;
    logic [31:0] crc, crc_next;
    logic [15:0] cnt, total;
    logic [3:0][7:0] dl;
    logic phy, crc_err, len_err, phy_err;
    always_comb begin
        crc_next = crc ^ {24'h0, rx_data_i};
        for (int i = 0; i < 8; i++)
            crc_next = crc_next[0] ? (crc_next >> 1) ^ 32'hEDB88320 : crc_next >> 1;
    end
    // total includes the byte being accepted now; the count saturates
    assign total   = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
    assign crc_err = crc_next != CRC_RESIDUE;
    // a frame ending before the delay line is full never carried any payload
    assign len_err = state != STREAM || 32'(total) < MIN_FRAME || 32'(total) > MAX_FRAME;
    assign phy_err = phy | rx_error_i;
    always_comb begin
        state_next = state;
        if (rx_valid_i) begin
            if (rx_last_i)
                state_next = IDLE;
            else if (state == IDLE)
                state_next = FILL;
            else if (state == FILL && cnt == 16'd3)
                state_next = STREAM;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            state <= IDLE;
        else
            state <= state_next;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            crc            <= '1;
            cnt            <= '0;
            dl             <= '0;
            phy            <= 1'b0;
            data_o         <= '0;
            valid_o        <= 1'b0;
            last_o         <= 1'b0;
            frame_done_o   <= 1'b0;
            frame_good_o   <= 1'b0;
            crc_error_o    <= 1'b0;
            length_error_o <= 1'b0;
            phy_error_o    <= 1'b0;
            frame_length_o <= '0;
        end else begin
            valid_o      <= 1'b0;
            last_o       <= 1'b0;
            frame_done_o <= 1'b0;
            if (rx_valid_i) begin
                dl <= {dl[2:0], rx_data_i};
                // the oldest held byte is payload once four newer bytes exist
                if (state == STREAM) begin
                    valid_o <= 1'b1;
                    data_o  <= dl[3];
                    last_o  <= rx_last_i;
                end
                if (rx_last_i) begin
                    crc            <= '1;
                    cnt            <= '0;
                    phy            <= 1'b0;
                    frame_done_o   <= 1'b1;
                    crc_error_o    <= crc_err;
                    length_error_o <= len_err;
                    phy_error_o    <= phy_err;
                    frame_good_o   <= !(crc_err || len_err || phy_err);
                    frame_length_o <= (total > 16'd4) ? total - 16'd4 : 16'd0;
                end else begin
                    crc <= crc_next;
                    cnt <= total;
                    phy <= phy_err;
                end
            end
        end
    end
endmodule

// File: tb/tb_ethernet_rx_fcs_checker.sv
// tb_ethernet_rx_fcs_checker: directed checks of payload stripping and frame status.
module tb_ethernet_rx_fcs_checker;
    logic clk = 1'b0, rst_n = 1'b0, rx_valid = 1'b0, rx_last = 1'b0, rx_error = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] data_min, data_def;
    logic [15:0] flen_min, flen_def;
    logic valid_min, last_min, done_min, good_min, crc_min, lerr_min, phy_min;
    logic valid_def, last_def, done_def, good_def, crc_def, lerr_def, phy_def;
    logic [8:0] q_min[$];
    logic [19:0] sq_min[$], sq_def[$];
    logic [19:0] st;
    int passed = 0, total = 0, coinc_bad = 0;

    always #5 clk = ~clk;

    ethernet_rx_fcs_checker #(.MIN_FRAME(1)) dut_min (
        .clk_i(clk), .rst_n_i(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .rx_last_i(rx_last), .rx_error_i(rx_error), .data_o(data_min), .valid_o(valid_min),
        .last_o(last_min), .frame_done_o(done_min), .frame_good_o(good_min),
        .crc_error_o(crc_min), .length_error_o(lerr_min), .phy_error_o(phy_min),
        .frame_length_o(flen_min));

    ethernet_rx_fcs_checker dut_def (
        .clk_i(clk), .rst_n_i(rst_n), .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .rx_last_i(rx_last), .rx_error_i(rx_error), .data_o(data_def), .valid_o(valid_def),
        .last_o(last_def), .frame_done_o(done_def), .frame_good_o(good_def),
        .crc_error_o(crc_def), .length_error_o(lerr_def), .phy_error_o(phy_def),
        .frame_length_o(flen_def));

    always @(negedge clk) begin
        if (valid_min) q_min.push_back({last_min, data_min});
        if (done_min) sq_min.push_back({good_min, crc_min, lerr_min, phy_min, flen_min});
        if (done_def) sq_def.push_back({good_def, crc_def, lerr_def, phy_def, flen_def});
        if (last_min != (done_min && flen_min != 16'd0)) coinc_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send(input logic [7:0] b, input logic l = 1'b0, input logic e = 1'b0);
        rx_valid = 1'b1; rx_data = b; rx_last = l; rx_error = e;
        @(negedge clk);
        rx_valid = 1'b0; rx_last = 1'b0; rx_error = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // "123456789" plus its FCS; optional symbol error and idle gap after given byte
    task automatic frame(input logic [7:0] fcs_last, input int err_at, input int gap_at);
        logic [7:0] fcs[4];
        fcs = '{8'h26, 8'h39, 8'hF4, fcs_last};
        for (int i = 1; i <= 9; i++) begin
            send(8'(8'h30 + i), 1'b0, i == err_at);
            if (i == gap_at) idle(2);
        end
        for (int i = 0; i < 4; i++) send(fcs[i], i == 3);
    endtask

    task automatic check_payload(input string tag, input int n);
        check({tag, " count"}, 32'(q_min.size()), 32'(n));
        for (int i = 0; i < n && i < q_min.size(); i++)
            check({tag, " byte"}, 32'(q_min[i]), 32'({i == n - 1, 8'(8'h31 + i)}));
        q_min.delete();
    endtask

    task automatic pop_min(input string tag);
        check({tag, " done"}, 32'(sq_min.size() > 0), 32'd1);
        st = (sq_min.size() > 0) ? sq_min.pop_front() : 20'hFFFFF;
    endtask

    task automatic pop_def(input string tag);
        check({tag, " done"}, 32'(sq_def.size() > 0), 32'd1);
        st = (sq_def.size() > 0) ? sq_def.pop_front() : 20'hFFFFF;
    endtask

    initial begin
        idle(3);
        check("reset outputs min", 32'({valid_min, last_min, done_min, good_min, crc_min, lerr_min, phy_min, data_min, flen_min}), 32'd0);
        check("reset outputs def", 32'({valid_def, last_def, done_def, good_def, crc_def, lerr_def, phy_def, data_def, flen_def}), 32'd0);
        rst_n = 1'b1;
        idle(2);

        frame(8'hCB, 0, 0);
        idle(4);
        check_payload("good frame", 9);
        pop_min("good frame min"); check("good frame min status", 32'(st), 32'h8_0009);
        pop_def("good frame def"); check("good frame def status", 32'(st), 32'h2_0009);

        frame(8'hCA, 0, 0);
        idle(4);
        check_payload("bad fcs", 9);
        pop_min("bad fcs min"); check("bad fcs min status", 32'(st), 32'h4_0009);
        pop_def("bad fcs def"); check("bad fcs def status", 32'(st), 32'h6_0009);

        send(8'h31); send(8'h32); send(8'h33, 1'b1);
        idle(4);
        check("short frame no payload", 32'(q_min.size()), 32'd0);
        pop_min("short min");
        check("short min len err", 32'(st[17]), 32'd1);
        check("short min good", 32'(st[19]), 32'd0);
        check("short min length", 32'(st[15:0]), 32'd0);
        pop_def("short def"); check("short def len err", 32'(st[17]), 32'd1);

        send(8'h31, 1'b1);
        idle(3);
        check("one byte no payload", 32'(q_min.size()), 32'd0);
        pop_min("one byte"); check("one byte length/len err", 32'({st[17], st[15:0]}), 32'h1_0000);
        pop_def("one byte def");

        for (int i = 1; i <= 5; i++) send(8'(8'h30 + i), i == 5);
        idle(4);
        check_payload("five byte", 1);
        pop_min("five byte min"); check("five byte min length/len err", 32'({st[17], st[15:0]}), 32'h0_0001);
        pop_def("five byte def"); check("five byte def len err", 32'(st[17]), 32'd1);

        frame(8'hCB, 5, 3);
        frame(8'hCB, 0, 0);
        idle(4);
        check("b2b payload count", 32'(q_min.size()), 32'd18);
        q_min.delete();
        pop_min("b2b first min"); check("b2b first min status", 32'(st), 32'h1_0009);
        pop_min("b2b second min"); check("b2b second min status", 32'(st), 32'h8_0009);
        pop_def("b2b first def"); check("b2b first def status", 32'(st), 32'h3_0009);
        pop_def("b2b second def"); check("b2b second def status", 32'(st), 32'h2_0009);

        for (int i = 1; i <= 6; i++) send(8'(8'h30 + i));
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(4);
        check("reset mid-frame no done", 32'(sq_min.size() + sq_def.size()), 32'd0);
        q_min.delete();
        frame(8'hCB, 0, 0);
        idle(4);
        check_payload("after reset", 9);
        pop_min("after reset min"); check("after reset min status", 32'(st), 32'h8_0009);
        pop_def("after reset def");

        check("last_o coincides with frame_done_o", 32'(coinc_bad), 32'd0);
        check("no stray frame_done_o", 32'(sq_min.size() + sq_def.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
